// File: rtl/linear_layer_fifo_pkg.sv
// Shared helpers for the Linear_Layer_i4xi4_q FIFOs: clog2 and elaboration-time parameter checks.
package linear_layer_fifo_pkg;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (longint unsigned p = 1; p < longint'(value); p = p << 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return depth >= 2;
    endfunction

    function automatic bit addr_width_ok(input int unsigned addr_width, input int unsigned depth);
        return clog2(depth) <= addr_width;
    endfunction

endpackage

// File: rtl/pe_start_token_fifo_if.sv
// Producer/consumer handshake bundle for the PE start-token FIFO.
interface pe_start_token_fifo_if #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] if_din;
    logic                  if_write;
    logic                  if_full_n;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  if_read;
    logic                  if_empty_n;
    logic [ADDR_WIDTH:0]   if_num_data_valid;

    modport slave (
        input  if_din, if_write, if_read,
        output if_full_n, if_dout, if_empty_n, if_num_data_valid
    );

    modport master (
        output if_din, if_write, if_read,
        input  if_full_n, if_dout, if_empty_n, if_num_data_valid
    );
endinterface

// File: rtl/pe_start_token_srl.sv
// Non-reset shift-register token storage with a combinational read mux (SRL-mappable).
module pe_start_token_srl #(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  shift_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] dout
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (shift_en) begin
            for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                mem[i] <= mem[i-1];
            end
            mem[0] <= din;
        end
    end

    assign dout = mem[raddr];
endmodule

// File: rtl/pe_start_token_fifo.sv
// Start-token FIFO feeding PE_i4xi4_pack_2x2: registered occupancy, flags and read address around SRL storage.
module pe_start_token_fifo
    import linear_layer_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned ADDR_WIDTH = 1,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    pe_start_token_fifo_if.slave fifo_if
);
    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $fatal(1, "pe_start_token_fifo: DEPTH must be >= 2");
    end
    if (!addr_width_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_addr_width
        $fatal(1, "pe_start_token_fifo: 2**ADDR_WIDTH must be >= DEPTH");
    end

    localparam logic [ADDR_WIDTH:0]   CNT_FULL  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] RADDR_ONE = ADDR_WIDTH'(1);

    logic                  wr_acc, rd_acc;
    logic [ADDR_WIDTH:0]   cnt, cnt_next;
    logic [ADDR_WIDTH-1:0] raddr, raddr_next;
    logic                  full_n, empty_n;

    assign wr_acc = fifo_if.if_write & full_n;
    assign rd_acc = fifo_if.if_read & empty_n;

    // raddr tracks cnt-1 but saturates at 0 across the empty/one-entry boundary
    always_comb begin
        cnt_next   = cnt;
        raddr_next = raddr;
        case ({wr_acc, rd_acc})
            2'b10: begin
                cnt_next = cnt + CNT_ONE;
                if (cnt != '0) raddr_next = raddr + RADDR_ONE;
            end
            2'b01: begin
                cnt_next = cnt - CNT_ONE;
                if (cnt != CNT_ONE) raddr_next = raddr - RADDR_ONE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt     <= '0;
            raddr   <= '0;
            full_n  <= 1'b1;
            empty_n <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            raddr   <= raddr_next;
            full_n  <= (cnt_next != CNT_FULL);
            empty_n <= (cnt_next != '0);
        end
    end

    pe_start_token_srl #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_srl (
        .clk      (ap_clk),
        .shift_en (wr_acc),
        .din      (fifo_if.if_din),
        .raddr    (raddr),
        .dout     (fifo_if.if_dout)
    );

    assign fifo_if.if_full_n         = full_n;
    assign fifo_if.if_empty_n        = empty_n;
    assign fifo_if.if_num_data_valid = cnt;
endmodule
